// File: rtl/qu_uop_dispatch_if.sv
// Dispatch-side bundle: upstream uop handshake, IC/LS head views, occupancy.
// Optional 0-cycle bypass lives in qu_uop_dispatch (QU_DISPATCH_BYPASS_EN).
interface qu_uop_dispatch_if #(
  parameter int IC_DEPTH = 8,
  parameter int LS_DEPTH = 4
);
  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic [65:0]                 in_uop;

  logic                        ic_valid;
  logic                        ic_ready;
  logic                        ic_is_cont;
  logic [3:0]                  ic_op_sel;
  logic [1:0]                  ic_res_sel;
  logic                        ic_opd34_sel;
  logic [6:0]                  ic_rd;
  logic [6:0]                  ic_rs1;
  logic [6:0]                  ic_rs2;
  logic [3:0]                  ic_vld;
  logic [31:0]                 ic_imm;

  logic                        ls_valid;
  logic                        ls_ready;
  logic                        ls_is_store;
  logic [2:0]                  ls_funct3;
  logic [6:0]                  ls_rd;
  logic [6:0]                  ls_rs1;
  logic [6:0]                  ls_rs2;
  logic [3:0]                  ls_vld;
  logic [31:0]                 ls_imm;

  logic [$clog2(IC_DEPTH):0]   ic_count;
  logic [$clog2(LS_DEPTH):0]   ls_count;

  modport master (
    output flush, in_valid, in_uop, ic_ready, ls_ready,
    input  in_ready,
    input  ic_valid, ic_is_cont, ic_op_sel, ic_res_sel, ic_opd34_sel,
    input  ic_rd, ic_rs1, ic_rs2, ic_vld, ic_imm,
    input  ls_valid, ls_is_store, ls_funct3,
    input  ls_rd, ls_rs1, ls_rs2, ls_vld, ls_imm,
    input  ic_count, ls_count
  );

  modport slave (
    input  flush, in_valid, in_uop, ic_ready, ls_ready,
    output in_ready,
    output ic_valid, ic_is_cont, ic_op_sel, ic_res_sel, ic_opd34_sel,
    output ic_rd, ic_rs1, ic_rs2, ic_vld, ic_imm,
    output ls_valid, ls_is_store, ls_funct3,
    output ls_rd, ls_rs1, ls_rs2, ls_vld, ls_imm,
    output ic_count, ls_count
  );
endinterface

// File: rtl/qu_uop_dispatch.sv
// Qu uop dispatch: steers uops into in-order IC and LS queues by optype.
// Define QU_DISPATCH_BYPASS_EN for 0-cycle head bypass into empty queues.
module qu_uop_dispatch #(
  parameter int IC_DEPTH = 8,
  parameter int LS_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  qu_uop_dispatch_if.slave bus
);
  localparam int ICW = $clog2(IC_DEPTH);
  localparam int LSW = $clog2(LS_DEPTH);

  typedef logic [65:0] uop_t;

  uop_t ic_mem [IC_DEPTH];
  uop_t ls_mem [LS_DEPTH];

  logic [ICW-1:0] ic_wp, ic_rp;
  logic [ICW:0]   ic_cnt;
  logic [LSW-1:0] ls_wp, ls_rp;
  logic [LSW:0]   ls_cnt;

  logic to_ls, acc;
  logic ic_full, ic_empty, ls_full, ls_empty;
  logic ic_push, ic_pop, ls_push, ls_pop;
  uop_t ic_head, ls_head;
  logic [3:0] ls_unused_ign;

  assign to_ls    = bus.in_uop[1];
  assign ic_full  = ic_cnt == (ICW+1)'(IC_DEPTH);
  assign ls_full  = ls_cnt == (LSW+1)'(LS_DEPTH);
  assign ic_empty = ic_cnt == '0;
  assign ls_empty = ls_cnt == '0;

  // full means no accept, even if the head pops this cycle
  assign bus.in_ready = !bus.flush &&
                        (to_ls ? !ls_full : !ic_full);
  assign acc = bus.in_valid && bus.in_ready;

`ifdef QU_DISPATCH_BYPASS_EN
  logic ic_byp, ls_byp;

  assign ic_byp = rst_n && ic_empty && bus.in_valid &&
                  !to_ls && !bus.flush;
  assign ls_byp = rst_n && ls_empty && bus.in_valid &&
                  to_ls && !bus.flush;

  assign bus.ic_valid = !ic_empty || ic_byp;
  assign bus.ls_valid = !ls_empty || ls_byp;
  assign ic_head = ic_empty ? bus.in_uop : ic_mem[ic_rp];
  assign ls_head = ls_empty ? bus.in_uop : ls_mem[ls_rp];

  // a bypassed uop taken by its cluster is never written
  assign ic_pop  = !ic_empty && bus.ic_ready;
  assign ls_pop  = !ls_empty && bus.ls_ready;
  assign ic_push = acc && !to_ls && !(ic_empty && bus.ic_ready);
  assign ls_push = acc && to_ls && !(ls_empty && bus.ls_ready);
`else
  assign bus.ic_valid = !ic_empty;
  assign bus.ls_valid = !ls_empty;
  assign ic_head = ic_mem[ic_rp];
  assign ls_head = ls_mem[ls_rp];

  assign ic_pop  = bus.ic_valid && bus.ic_ready;
  assign ls_pop  = bus.ls_valid && bus.ls_ready;
  assign ic_push = acc && !to_ls;
  assign ls_push = acc && to_ls;
`endif

  always_ff @(posedge clk) begin
    if (ic_push) ic_mem[ic_wp] <= bus.in_uop;
    if (ls_push) ls_mem[ls_wp] <= bus.in_uop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_wp  <= '0;
      ic_rp  <= '0;
      ic_cnt <= '0;
    end else if (bus.flush) begin
      ic_wp  <= '0;
      ic_rp  <= '0;
      ic_cnt <= '0;
    end else begin
      if (ic_push) ic_wp <= ic_wp + 1'b1;
      if (ic_pop)  ic_rp <= ic_rp + 1'b1;
      case ({ic_push, ic_pop})
        2'b10:   ic_cnt <= ic_cnt + 1'b1;
        2'b01:   ic_cnt <= ic_cnt - 1'b1;
        default: ic_cnt <= ic_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_wp  <= '0;
      ls_rp  <= '0;
      ls_cnt <= '0;
    end else if (bus.flush) begin
      ls_wp  <= '0;
      ls_rp  <= '0;
      ls_cnt <= '0;
    end else begin
      if (ls_push) ls_wp <= ls_wp + 1'b1;
      if (ls_pop)  ls_rp <= ls_rp + 1'b1;
      case ({ls_push, ls_pop})
        2'b10:   ls_cnt <= ls_cnt + 1'b1;
        2'b01:   ls_cnt <= ls_cnt - 1'b1;
        default: ls_cnt <= ls_cnt;
      endcase
    end
  end

  assign bus.ic_count = ic_cnt;
  assign bus.ls_count = ls_cnt;

  assign bus.ic_is_cont   = ic_head[1:0] == 2'b01;
  assign bus.ic_op_sel    = ic_head[8:5];
  assign bus.ic_res_sel   = ic_head[4:3];
  assign bus.ic_opd34_sel = ic_head[2];
  assign bus.ic_vld       = ic_head[12:9];
  assign bus.ic_rd        = ic_head[19:13];
  assign bus.ic_rs1       = ic_head[26:20];
  assign bus.ic_rs2       = ic_head[33:27];
  assign bus.ic_imm       = ic_head[65:34];

  assign bus.ls_is_store  = ls_head[1:0] == 2'b11;
  assign ls_unused_ign    = ls_head[8:5];
  assign bus.ls_funct3    = ls_head[4:2];
  assign bus.ls_vld       = ls_head[12:9];
  assign bus.ls_rd        = ls_head[19:13];
  assign bus.ls_rs1       = ls_head[26:20];
  assign bus.ls_rs2       = ls_head[33:27];
  assign bus.ls_imm       = ls_head[65:34];
endmodule
